// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and types for the seven-segment display
//                blocks: hex-to-segment table, digit count, all-off common
//                pattern and the frame record used for digit buffering.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   // Commons are active low; this pattern turns every digit off.
   localparam logic [NUM_DIGITS-1:0] COM_ALL_OFF = 4'b1111;

   // Segment patterns {g,f,e,d,c,b,a}, active high. Entry 0 is the
   // rightmost element of the concatenation, so SEG_TABLE[n] decodes n.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'b1110001,  // F
      7'b1111001,  // E
      7'b1011110,  // d
      7'b1011000,  // c
      7'b1111100,  // b
      7'b1110111,  // A
      7'b1101111,  // 9
      7'b1111111,  // 8
      7'b0000111,  // 7
      7'b1111101,  // 6
      7'b1101101,  // 5
      7'b1100110,  // 4
      7'b1001111,  // 3
      7'b1011011,  // 2
      7'b0000110,  // 1
      7'b0111111   // 0
   };

   // One buffered frame: four hex nibbles plus their decimal points.
   typedef struct packed {
      logic [4*NUM_DIGITS-1:0] digits;
      logic [NUM_DIGITS-1:0]   dp;
   } frame_t;

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Combinational hex nibble to seven-segment decoder with a
//                blank override that forces every segment off.
//  Ports       : nibble  [3:0] in  - hex value to show
//                blank         in  - 1 forces segment to all zeros
//                segment [6:0] out - {g,f,e,d,c,b,a}, active high
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       blank,
   output logic [6:0] segment
);

   always_comb begin
      segment = blank ? 7'b0000000 : SEG_TABLE[nibble];
   end

endmodule
`default_nettype wire

// File: rtl/seg7_scan4.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan4
//  Description : Four-digit multiplexed seven-segment driver. Double-buffers
//                loaded digits so a frame never tears, scans one digit per
//                DIV_COUNT cycles with a one-cycle all-off gap between
//                digits, and optionally blanks leading zeros.
//  Ports       : clk, rst_n          - clock, synchronous active-low reset
//                digits[15:0], dp[3:0], load - frame data and load strobe
//                blank_lz            - leading-zero blanking enable
//                com[3:0]            - digit commons, active low
//                segment[6:0], dp_out - active digit segments / point
//                frame_done          - one-cycle pulse per frame boundary
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan4
   import seg7_pkg::*;
#(
   parameter int DIV_COUNT = 25000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] digits,
   input  logic [3:0]  dp,
   input  logic        load,
   input  logic        blank_lz,
   output logic [3:0]  com,
   output logic [6:0]  segment,
   output logic        dp_out,
   output logic        frame_done
);

   localparam int               DIV_W    = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic [1:0]       idx_q, idx_d;
   logic             tick_dly_q, tick_dly_d;   // tick delayed to the output stage
   logic             gap_q, gap_d;             // high during the all-off gap cycle
   logic             pend_vld_q, pend_vld_d;
   frame_t           pend_q, pend_d;
   frame_t           disp_q, disp_d;
   logic [3:0]       com_q, com_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_out_q, dp_out_d;
   logic             frame_done_q, frame_done_d;

   logic             tick;
   logic             boundary;
   frame_t           load_frame;
   logic [3:0]       lz_blank;
   logic [3:0]       sel_nibble;
   logic [6:0]       sel_seg;

   assign load_frame = '{digits: digits, dp: dp};

   // A digit is blanked only when it and every digit to its left are zero.
   assign lz_blank[NUM_DIGITS-1] = blank_lz && (disp_q.digits[15:12] == 4'h0);
   for (genvar gi = NUM_DIGITS - 2; gi >= 1; gi--) begin : g_lz
      assign lz_blank[gi] = lz_blank[gi+1] && (disp_q.digits[4*gi +: 4] == 4'h0);
   end
   assign lz_blank[0] = 1'b0;

   assign sel_nibble = disp_q.digits[{idx_q, 2'b00} +: 4];

   seg7_decode u_decode (
      .nibble  (sel_nibble),
      .blank   (lz_blank[idx_q]),
      .segment (sel_seg)
   );

   always_comb begin
      tick     = (div_q == DIV_LAST);
      boundary = tick && (idx_q == 2'd3);

      div_d = tick ? '0 : div_q + DIV_W'(1);
      idx_d = tick ? idx_q + 2'd1 : idx_q;

      // A load on the boundary edge bypasses the pending stage entirely.
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      disp_d     = disp_q;
      if (load) begin
         if (boundary) begin
            disp_d     = load_frame;
            pend_vld_d = 1'b0;
         end else begin
            pend_d     = load_frame;
            pend_vld_d = 1'b1;
         end
      end else if (boundary && pend_vld_q) begin
         disp_d     = pend_q;
         pend_vld_d = 1'b0;
      end

      // Output stage runs one edge behind the index: on the edge after a
      // tick the new digit is presented with every common off, and the
      // common is enabled one edge after that.
      tick_dly_d   = tick;
      gap_d        = tick_dly_q;
      com_d        = com_q;
      seg_d        = seg_q;
      dp_out_d     = dp_out_q;
      if (tick_dly_q) begin
         com_d    = COM_ALL_OFF;
         seg_d    = sel_seg;
         dp_out_d = disp_q.dp[idx_q];
      end else if (gap_q) begin
         com_d    = ~(4'b0001 << idx_q);
      end
      frame_done_d = tick_dly_q && (idx_q == 2'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_q        <= '0;
         idx_q        <= 2'd0;
         tick_dly_q   <= 1'b0;
         gap_q        <= 1'b0;
         pend_vld_q   <= 1'b0;
         pend_q       <= '0;
         disp_q       <= '0;
         com_q        <= COM_ALL_OFF;
         seg_q        <= 7'b0000000;
         dp_out_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         idx_q        <= idx_d;
         tick_dly_q   <= tick_dly_d;
         gap_q        <= gap_d;
         pend_vld_q   <= pend_vld_d;
         pend_q       <= pend_d;
         disp_q       <= disp_d;
         com_q        <= com_d;
         seg_q        <= seg_d;
         dp_out_q     <= dp_out_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign com        = com_q;
   assign segment    = seg_q;
   assign dp_out     = dp_out_q;
   assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan4
//  Description : Self-checking bench for seg7_scan4 with DIV_COUNT=4.
//                A reference model derives the expected outputs from the
//                number of clock edges since reset and pushes them into a
//                queue; a monitor pops and compares every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan4;

   localparam int D = 4;

   typedef struct packed {
      logic [3:0] com;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] digits;
   logic [3:0]  dp;
   logic        load;
   logic        blank_lz;
   logic [3:0]  com;
   logic [6:0]  segment;
   logic        dp_out;
   logic        frame_done;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   logic [6:0] seg_ref [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b1011000, 7'b1011110, 7'b1111001, 7'b1110001
   };

   seg7_scan4 #(.DIV_COUNT(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .digits     (digits),
      .dp         (dp),
      .load       (load),
      .blank_lz   (blank_lz),
      .com        (com),
      .segment    (segment),
      .dp_out     (dp_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int          n_m = 0;          // edges since the last reset edge
   bit          flag_m;
   logic [15:0] pend_m, disp_m;
   logic [3:0]  pend_dp_m, disp_dp_m;
   logic [6:0]  hold_seg;
   logic        hold_dp;

   function automatic bit is_bnd(input int m);
      // Ticks fall on edges D, 2D, ...; every fourth one ends a frame.
      return (m > 0) && (m % D == 0) && ((m / D) % 4 == 0);
   endfunction

   always @(posedge clk) begin
      exp_t e;
      int   k, p, i;
      if (!rst_n) begin
         n_m = 0; flag_m = 0;
         pend_m = '0; disp_m = '0; pend_dp_m = '0; disp_dp_m = '0;
         hold_seg = '0; hold_dp = 1'b0;
         e = '{com: 4'hF, seg: 7'd0, dp: 1'b0, fd: 1'b0};
      end else begin
         n_m++;
         if (load) begin
            if (is_bnd(n_m)) begin
               disp_m = digits; disp_dp_m = dp; flag_m = 0;
            end else begin
               pend_m = digits; pend_dp_m = dp; flag_m = 1;
            end
         end else if (is_bnd(n_m) && flag_m) begin
            disp_m = pend_m; disp_dp_m = pend_dp_m; flag_m = 0;
         end
         if (n_m <= D) begin
            e = '{com: 4'hF, seg: 7'd0, dp: 1'b0, fd: 1'b0};
         end else begin
            k = (n_m - 1) / D;        // ticks already behind us
            p = n_m - k * D;          // 1 = gap cycle, 2..D = digit lit
            i = k % 4;
            if (p == 1) begin
               if (blank_lz && i > 0 && ((disp_m >> (4 * i)) == 16'h0))
                  hold_seg = 7'd0;
                  else hold_seg = seg_ref[(disp_m >> (4 * i)) & 16'hF];
               hold_dp = disp_dp_m[i];
            end
            e.com = (p == 1) ? 4'hF : ~(4'b0001 << i);
            e.seg = hold_seg;
            e.dp  = hold_dp;
            e.fd  = (p == 1) && (i == 0);
         end
      end
      exp_q.push_back(e);
   end

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      int   lows;
      forever begin
         @(posedge clk);
         #1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty at %0t: no expected entry", $time);
         end else begin
            e = exp_q.pop_front();
            if (com !== e.com || segment !== e.seg || dp_out !== e.dp || frame_done !== e.fd) begin
               errors++;
               $display("FAIL outputs at %0t: got com=%b seg=%b dp=%b fd=%b want com=%b seg=%b dp=%b fd=%b",
                        $time, com, segment, dp_out, frame_done, e.com, e.seg, e.dp, e.fd);
            end
         end
         lows = 0;
         for (int b = 0; b < 4; b++) if (com[b] === 1'b0) lows++;
         checks++;
         if (lows > 1) begin
            errors++;
            $display("FAIL com_onehot at %0t: got com=%b want at most one low bit", $time, com);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic l, input logic [15:0] d, input logic [3:0] p);
      load = l; digits = d; dp = p;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic idle(input int cnt);
      for (int c = 0; c < cnt; c++) cyc(1'b0, $urandom, $urandom);
   endtask

   // Leaves the bench so that the next posedge is a frame boundary.
   task automatic to_boundary();
      for (int c = 0; c < 64 && !is_bnd(n_m + 1); c++) idle(1);
   endtask

   initial begin
      rst_n = 1'b0; load = 1'b0; digits = '0; dp = '0; blank_lz = 1'b0;
      @(negedge clk);
      idle(3);
      rst_n = 1'b1;
      idle(20);
      // Mid-scan reset discards a pending load.
      cyc(1'b1, 16'h1234, 4'hF);
      idle(2);
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(30);
      // Load and commit.
      cyc(1'b1, 16'h12AF, 4'b0100);
      idle(48);
      // Tear-free update: two loads inside one frame.
      to_boundary();
      idle(5);
      cyc(1'b1, 16'h1111, 4'h0);
      idle(4);
      cyc(1'b1, 16'h2222, 4'h0);
      idle(40);
      // Load exactly on the boundary edge.
      to_boundary();
      cyc(1'b1, 16'h0005, 4'h1);
      idle(40);
      // Leading-zero blanking.
      blank_lz = 1'b1;
      cyc(1'b1, 16'h0050, 4'h0);
      idle(40);
      blank_lz = 1'b0;
      idle(32);
      blank_lz = 1'b1;
      cyc(1'b1, 16'h0000, 4'hA);
      idle(40);
      // Randomised run, roughly 100 frames.
      for (int c = 0; c < 1700; c++) begin
         if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0;
            idle($urandom_range(1, 3));
            rst_n = 1'b1;
         end
         cyc($urandom_range(0, 7) == 0, $urandom, $urandom);
      end
      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
